// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: walks a word index through code memory, buffers
// responses in a 2-entry FIFO and presents {pc, instr} over valid/ready.
module fetch_sequencer #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter logic [31:0] STOP_AT   = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_pc,
    output logic [31:0]       inst_data,
    output logic              halt,
    output logic              fault
);

    localparam int unsigned IW = ADDR_W + 1;
    localparam logic [IW-1:0] STOP_IDX = IW'(STOP_AT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HALTED
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      index_q, index_d;
    logic [1:0]         count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  resp_idx_q, resp_idx_d;
    logic [31:0]        pc0_q, pc0_d, data0_q, data0_d;
    logic [31:0]        pc1_q, pc1_d, data1_q, data1_d;
    logic               halt_q, halt_d;
    logic               fault_q, fault_d;

    logic               pop;
    logic               push;
    logic               issue;
    logic               redir_act;
    logic               redir_ok;
    logic [31:0]        redir_tgt;
    logic [2:0]         slots;
    logic [31:0]        push_pc;

    assign pop       = (count_q != 2'd0) && inst_ready;
    assign push      = inflight_q;
    assign push_pc   = BASE_ADDR + (32'(resp_idx_q) << 2);

    // A word popped this cycle frees its slot, which keeps one issue per cycle.
    assign slots     = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == S_FETCH) && !redirect_valid
                       && (slots < 3'd2) && (index_q < STOP_IDX);

    assign redir_act = redirect_valid && ((state_q == S_FETCH) || (state_q == S_DRAIN));
    assign redir_tgt = (redirect_pc - BASE_ADDR) >> 2;
    assign redir_ok  = (redirect_pc[1:0] == 2'b00) && (redirect_pc >= BASE_ADDR)
                       && (redir_tgt < STOP_AT);

    assign mem_rd_en  = issue;
    assign mem_addr   = issue ? index_q[ADDR_W-1:0] : '0;
    assign inst_valid = (count_q != 2'd0);
    assign inst_pc    = pc0_q;
    assign inst_data  = data0_q;
    assign halt       = halt_q;
    assign fault      = fault_q;

    // Next-state: issue bookkeeping, FIFO shift, then FSM and redirect overrides.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        inflight_d = issue;
        resp_idx_d = resp_idx_q;
        pc0_d      = pc0_q;
        data0_d    = data0_q;
        pc1_d      = pc1_q;
        data1_d    = data1_q;
        halt_d     = halt_q;
        fault_d    = fault_q;

        if (issue) begin
            index_d    = index_q + IW'(1);
            resp_idx_d = index_q[ADDR_W-1:0];
        end

        if (pop && push) begin
            if (count_q == 2'd2) begin
                pc0_d   = pc1_q;
                data0_d = data1_q;
                pc1_d   = push_pc;
                data1_d = mem_rdata;
            end else begin
                pc0_d   = push_pc;
                data0_d = mem_rdata;
            end
        end else if (pop) begin
            pc0_d   = pc1_q;
            data0_d = data1_q;
            count_d = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                pc0_d   = push_pc;
                data0_d = mem_rdata;
            end else begin
                pc1_d   = push_pc;
                data1_d = mem_rdata;
            end
            count_d = count_q + 2'd1;
        end

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d    = S_FETCH;
                    index_d    = '0;
                    count_d    = '0;
                    inflight_d = 1'b0;
                    halt_d     = 1'b0;
                    fault_d    = 1'b0;
                end
            end
            S_FETCH: begin
                if (index_q == STOP_IDX) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = S_HALTED;
                    halt_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect flushes buffered and in-flight words; it takes priority over start.
        if (redir_act) begin
            count_d    = '0;
            inflight_d = 1'b0;
            if (redir_ok) begin
                state_d = S_FETCH;
                index_d = IW'(redir_tgt);
            end else begin
                state_d = S_HALTED;
                halt_d  = 1'b1;
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            resp_idx_q <= '0;
            pc0_q      <= '0;
            data0_q    <= '0;
            pc1_q      <= '0;
            data1_q    <= '0;
            halt_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            resp_idx_q <= resp_idx_d;
            pc0_q      <= pc0_d;
            data0_q    <= data0_d;
            pc1_q      <= pc1_d;
            data1_q    <= data1_d;
            halt_q     <= halt_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three instances (STOP_AT 4/16/4096) checked against an
// expected-word-stream model over random memory contents.
module tb_fetch_sequencer;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st [ND];
    logic        rv [ND];
    logic [31:0] rpc [ND];
    logic        rdy [ND];
    logic        rd [ND];
    logic [11:0] addr [ND];
    logic        v [ND];
    logic [31:0] pcs [ND];
    logic [31:0] dat [ND];
    logic        hlt [ND];
    logic        flt [ND];
    logic [31:0] mem [4096];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [31:0] rdata_g;
        fetch_sequencer #(
            .ADDR_W   (12),
            .BASE_ADDR(BASE),
            .STOP_AT  (g == 0 ? 32'd4 : (g == 1 ? 32'd16 : 32'd4096))
        ) u_dut (
            .clk           (clk),
            .reset         (rst_n),
            .start         (st[g]),
            .redirect_valid(rv[g]),
            .redirect_pc   (rpc[g]),
            .mem_rd_en     (rd[g]),
            .mem_addr      (addr[g]),
            .mem_rdata     (rdata_g),
            .inst_valid    (v[g]),
            .inst_ready    (rdy[g]),
            .inst_pc       (pcs[g]),
            .inst_data     (dat[g]),
            .halt          (hlt[g]),
            .fault         (flt[g])
        );
        always @(posedge clk) if (rd[g]) rdata_g <= mem[addr[g]];
    end

    int n_chk = 0;
    int n_pass = 0;

    // Model: next word index each instance must deliver/issue; stop value means "none allowed".
    logic [31:0] exp_next [ND];
    logic [31:0] iss_next [ND];
    logic [31:0] xfer [ND];
    logic        hold [ND];
    logic [31:0] hpc [ND];
    logic [31:0] hdat [ND];
    logic        tog [ND];
    logic        s_v [ND], s_rd [ND], s_halt [ND], s_fault [ND];
    logic [31:0] s_pc [ND], s_data [ND];
    logic [11:0] s_addr [ND];

    function automatic logic [31:0] stop_of(input int d);
        return (d == 0) ? 32'd4 : ((d == 1) ? 32'd16 : 32'd4096);
    endfunction

    function automatic logic redir_legal(input logic [31:0] pc, input logic [31:0] stop);
        logic [31:0] tgt;
        tgt = (pc - BASE) >> 2;
        return (pc[1:0] == 2'b00) && (pc >= BASE) && (tgt < stop);
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
    endtask

    task automatic mon();
        for (int d = 0; d < ND; d++) begin
            s_v[d] = v[d];  s_rd[d] = rd[d];  s_halt[d] = hlt[d];  s_fault[d] = flt[d];
            s_pc[d] = pcs[d];  s_data[d] = dat[d];  s_addr[d] = addr[d];
            if (!rst_n) begin
                exp_next[d] = stop_of(d);
                iss_next[d] = stop_of(d);
                hold[d] = 1'b0;
                continue;
            end
            if (rd[d]) begin
                chk("issue_in_range", d, 32'(iss_next[d] < stop_of(d)), 32'd1);
                chk("issue_addr", d, 32'(addr[d]), 32'(iss_next[d][11:0]));
                iss_next[d] = iss_next[d] + 32'd1;
            end
            if (hold[d]) begin
                chk("stall_valid", d, 32'(v[d]), 32'd1);
                chk("stall_pc", d, pcs[d], hpc[d]);
                chk("stall_data", d, dat[d], hdat[d]);
            end
            if (v[d] && rdy[d]) begin
                chk("xfer_in_range", d, 32'(exp_next[d] < stop_of(d)), 32'd1);
                chk("xfer_pc", d, pcs[d], BASE + (exp_next[d] << 2));
                chk("xfer_data", d, dat[d], mem[exp_next[d][11:0]]);
                exp_next[d] = exp_next[d] + 32'd1;
                xfer[d] = xfer[d] + 32'd1;
            end
            hold[d] = v[d] && !rdy[d] && !rv[d];
            hpc[d]  = pcs[d];
            hdat[d] = dat[d];
            if (st[d]) begin
                exp_next[d] = 32'd0;
                iss_next[d] = 32'd0;
                xfer[d] = 32'd0;
            end
            if (rv[d]) begin
                if (redir_legal(rpc[d], stop_of(d))) begin
                    exp_next[d] = (rpc[d] - BASE) >> 2;
                    iss_next[d] = (rpc[d] - BASE) >> 2;
                end else begin
                    exp_next[d] = stop_of(d);
                    iss_next[d] = stop_of(d);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) if (tog[d]) rdy[d] = ~rdy[d];
    endtask

    task automatic pulse_start(input int d);
        st[d] = 1'b1;
        step();
        st[d] = 1'b0;
    endtask

    task automatic redirect(input int d, input logic [31:0] pc);
        rv[d] = 1'b1;
        rpc[d] = pc;
        step();
        rv[d] = 1'b0;
    endtask

    task automatic run_halt(input int d, input int bound, output int used);
        used = 0;
        do begin
            step();
            used++;
        end while (!s_halt[d] && used < bound);
        chk("halt_reached", d, 32'(s_halt[d]), 32'd1);
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < ND; d++) begin
            chk("rst_rd_en", d, 32'(rd[d]), 32'd0);
            chk("rst_addr", d, 32'(addr[d]), 32'd0);
            chk("rst_valid", d, 32'(v[d]), 32'd0);
            chk("rst_pc", d, pcs[d], 32'd0);
            chk("rst_data", d, dat[d], 32'd0);
            chk("rst_halt", d, 32'(hlt[d]), 32'd0);
            chk("rst_fault", d, 32'(flt[d]), 32'd0);
        end
    endtask

    task automatic check_fault_state(input int d);
        chk("bad_redir_halt", d, 32'(s_halt[d]), 32'd1);
        chk("bad_redir_fault", d, 32'(s_fault[d]), 32'd1);
        chk("bad_redir_valid", d, 32'(s_v[d]), 32'd0);
        chk("bad_redir_rd_en", d, 32'(s_rd[d]), 32'd0);
    endtask

    initial begin
        int used;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            st[d] = 1'b0;  rv[d] = 1'b0;  rpc[d] = 32'd0;  rdy[d] = 1'b0;  tog[d] = 1'b0;
            exp_next[d] = stop_of(d);  iss_next[d] = stop_of(d);  xfer[d] = 32'd0;
            hold[d] = 1'b0;  hpc[d] = 32'd0;  hdat[d] = 32'd0;
        end
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        #2;
        check_reset_outputs();
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        // STOP_AT=4, ready held: latency and four in-order transfers.
        rdy[0] = 1'b1;
        st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        chk("lat_c0_rd_en", 0, 32'(s_rd[0]), 32'd0);
        step();
        chk("lat_c1_rd_en", 0, 32'(s_rd[0]), 32'd1);
        chk("lat_c1_addr", 0, 32'(s_addr[0]), 32'd0);
        step();
        chk("lat_c2_valid", 0, 32'(s_v[0]), 32'd0);
        step();
        chk("lat_c3_valid", 0, 32'(s_v[0]), 32'd1);
        chk("lat_c3_pc", 0, s_pc[0], 32'h0001_0000);
        chk("lat_c3_data", 0, s_data[0], mem[0]);
        run_halt(0, 20, used);
        chk("stop4_count", 0, xfer[0], 32'd4);
        chk("stop4_fault", 0, 32'(s_fault[0]), 32'd0);
        chk("stop4_valid", 0, 32'(s_v[0]), 32'd0);
        repeat (3) step();
        chk("halt_held", 0, 32'(s_halt[0]), 32'd1);

        // STOP_AT=16 with ready toggling every cycle.
        rdy[1] = 1'b1;
        tog[1] = 1'b1;
        pulse_start(1);
        run_halt(1, 200, used);
        tog[1] = 1'b0;
        chk("toggle_count", 1, xfer[1], 32'd16);

        // Redirect while the buffer is full and the consumer stalled.
        rdy[1] = 1'b0;
        pulse_start(1);
        repeat (6) step();
        chk("full_valid", 1, 32'(s_v[1]), 32'd1);
        redirect(1, 32'h0001_0020);
        step();
        chk("redir_flush_valid", 1, 32'(s_v[1]), 32'd0);
        rdy[1] = 1'b1;
        for (int i = 0; i < 8 && !s_v[1]; i++) step();
        chk("redir_pc", 1, s_pc[1], 32'h0001_0020);
        chk("redir_data", 1, s_data[1], mem[8]);
        run_halt(1, 60, used);
        chk("redir_count", 1, xfer[1], 32'd8);

        // Redirect while streaming: the head accepted in the redirect cycle still counts.
        pulse_start(1);
        repeat (4) step();
        redirect(1, 32'h0001_0030);
        run_halt(1, 60, used);
        chk("redir_stream_count", 1, xfer[1], 32'd7);

        // Illegal redirects: misaligned, below base, target at STOP_AT.
        pulse_start(1);
        repeat (4) step();
        redirect(1, 32'h0001_0002);
        step();
        check_fault_state(1);
        pulse_start(1);
        step();
        chk("start_clr_halt", 1, 32'(s_halt[1]), 32'd0);
        chk("start_clr_fault", 1, 32'(s_fault[1]), 32'd0);
        repeat (2) step();
        redirect(1, 32'h0000_FFFC);
        step();
        check_fault_state(1);
        pulse_start(1);
        repeat (3) step();
        redirect(1, 32'h0001_0040);
        step();
        check_fault_state(1);
        pulse_start(1);
        run_halt(1, 60, used);
        chk("after_fault_count", 1, xfer[1], 32'd16);
        chk("after_fault_fault", 1, 32'(s_fault[1]), 32'd0);

        // Full memory walk: no wrap, one word per cycle.
        rdy[2] = 1'b1;
        pulse_start(2);
        run_halt(2, 4200, used);
        chk("max_count", 2, xfer[2], 32'd4096);
        chk("max_throughput", 2, 32'(used <= 4101), 32'd1);

        // Reset in the middle of a fetch with words buffered and in flight.
        rdy[1] = 1'b0;
        pulse_start(1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step();
        step();
        rst_n = 1'b1;
        for (int d = 0; d < ND; d++) rdy[d] = 1'b1;
        repeat (10) step();
        chk("post_reset_valid", 1, 32'(s_v[1]), 32'd0);
        chk("post_reset_halt", 1, 32'(s_halt[1]), 32'd0);
        chk("post_reset_rd_en", 1, 32'(s_rd[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
